qoi_stream_decoder: RTL



---
 rtl/qoi_pkg.sv | 19 +
 rtl/qoi_index_table.sv | 30 +++
 rtl/qoi_stream_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/qoi_pkg.sv
// Shared types and helpers for the QOI-style stream decoder.
package qoi_pkg;
    typedef enum logic [1:0] {OP_INDEX = 2'b00, OP_DIFF = 2'b01, OP_FULL = 2'b10, OP_RUN = 2'b11} opcode_e;
    typedef enum logic [1:0] {S_OP, S_FULL, S_RUN} state_e;

    localparam int DIFF_BIAS = 2;

    // 12 bits covers 15 * (2^CH_BITS - 1) for every legal channel width up to 8.
    function automatic int qoi_hash(input logic [23:0] pixel, input int ch_bits, input int idx_depth);
        logic [23:0] mask;
        logic [11:0] r, g, b, h;
        mask = (24'd1 << ch_bits) - 24'd1;
        r = 12'((pixel >> (2 * ch_bits)) & mask);
        g = 12'((pixel >> ch_bits) & mask);
        b = 12'(pixel & mask);
        h = 12'(3 * r + 5 * g + 7 * b);
        return int'(h & 12'(idx_depth - 1));
    endfunction
endpackage

// File: rtl/qoi_index_table.sv
// Colour index table: flop storage, per-entry valid, combinational read, one-cycle clear.
module qoi_index_table #(
    parameter int IDX_DEPTH = 64,
    parameter int PIX_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(IDX_DEPTH)-1:0] waddr,
    input  logic [PIX_W-1:0]             wdata,
    input  logic                         clear_all,
    input  logic [$clog2(IDX_DEPTH)-1:0] raddr,
    output logic [PIX_W-1:0]             rdata
);
    logic [PIX_W-1:0]     mem [IDX_DEPTH];
    logic [IDX_DEPTH-1:0] vld;

    // Clear wins over a same-cycle write: the frame's last pixel must not survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         vld <= '0;
        else if (clear_all) vld <= '0;
        else if (we)        vld[waddr] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = vld[raddr] ? mem[raddr] : '0;
endmodule

// File: rtl/qoi_stream_decoder.sv
// Streaming QOI-style decoder: one byte in, one packed {R,G,B} pixel out per cycle.
module qoi_stream_decoder
    import qoi_pkg::*;
#(
    parameter int CH_BITS      = 4,
    parameter int IDX_DEPTH    = 64,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 pix_valid,
    output logic [3*CH_BITS-1:0] pix_data,
    input  logic                 pix_ready,
    output logic                 pix_last,
    output logic                 run_trunc
);
    localparam int PIX_W = 3 * CH_BITS;
    localparam int NB    = (PIX_W > 6) ? (PIX_W - 6 + 7) / 8 : 0;
    localparam int ACC_W = 6 + 8 * NB;
    localparam int AW    = $clog2(IDX_DEPTH);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    state_e           state, state_nxt;
    logic [1:0]       bcnt, bcnt_nxt;
    logic [5:0]       rem, rem_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [PIX_W-1:0] prev, new_pix, tbl_rdata;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    waddr;
    logic             slot_free, fire, load, last, trunc;
    opcode_e          op;

    assign slot_free = !pix_valid || pix_ready;
    assign fire      = in_valid && in_ready;
    assign op        = opcode_e'(in_data[7:6]);
    assign last      = (count == CNT_W'(FRAME_PIXELS - 1));
    assign waddr     = AW'(qoi_hash(24'(new_pix), CH_BITS, IDX_DEPTH));

    qoi_index_table #(.IDX_DEPTH(IDX_DEPTH), .PIX_W(PIX_W)) u_tbl (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (load),
        .waddr    (waddr),
        .wdata    (new_pix),
        .clear_all(load && last),
        .raddr    (in_data[AW-1:0]),
        .rdata    (tbl_rdata)
    );

    always_comb begin
        in_ready  = 1'b0;
        load      = 1'b0;
        trunc     = 1'b0;
        new_pix   = prev;
        state_nxt = state;
        bcnt_nxt  = bcnt;
        rem_nxt   = rem;
        acc_nxt   = acc;
        case (state)
            S_OP: begin
                in_ready = rst_n && slot_free;
                if (fire) begin
                    case (op)
                        OP_INDEX: begin
                            load    = 1'b1;
                            new_pix = tbl_rdata;
                        end
                        OP_DIFF: begin
                            load = 1'b1;
                            for (int c = 0; c < 3; c++)
                                new_pix[c*CH_BITS +: CH_BITS] = prev[c*CH_BITS +: CH_BITS]
                                    + CH_BITS'(in_data[2*c +: 2]) - CH_BITS'(DIFF_BIAS);
                        end
                        OP_FULL: begin
                            if (NB == 0) begin
                                load    = 1'b1;
                                new_pix = PIX_W'(in_data[5:0]);
                            end else begin
                                state_nxt = S_FULL;
                                bcnt_nxt  = 2'(NB);
                                acc_nxt   = ACC_W'(in_data[5:0]);
                            end
                        end
                        default: begin
                            load = 1'b1;
                            if (in_data[5:0] != 6'd0) begin
                                state_nxt = S_RUN;
                                rem_nxt   = in_data[5:0];
                            end
                        end
                    endcase
                end
            end
            S_FULL: begin
                // Only the final payload byte needs somewhere to put the pixel.
                in_ready = rst_n && ((bcnt != 2'd1) || slot_free);
                if (fire) begin
                    acc_nxt  = ACC_W'({acc, in_data});
                    bcnt_nxt = bcnt - 2'd1;
                    if (bcnt == 2'd1) begin
                        load      = 1'b1;
                        new_pix   = PIX_W'({acc, in_data});
                        state_nxt = S_OP;
                    end
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    load    = 1'b1;
                    rem_nxt = rem - 6'd1;
                    if (rem == 6'd1) state_nxt = S_OP;
                end
            end
            default: state_nxt = S_OP;
        endcase
        if (load && last) begin
            trunc     = (state_nxt == S_RUN);
            state_nxt = S_OP;
            rem_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OP;
            bcnt      <= '0;
            rem       <= '0;
            acc       <= '0;
            prev      <= '0;
            count     <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_last  <= 1'b0;
            run_trunc <= 1'b0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            rem   <= rem_nxt;
            acc   <= acc_nxt;
            if (load) begin
                pix_valid <= 1'b1;
                pix_data  <= new_pix;
                pix_last  <= last;
                prev      <= last ? '0 : new_pix;
                count     <= last ? '0 : count + CNT_W'(1);
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
            if (trunc) run_trunc <= 1'b1;
        end
    end
endmodule
